// File: rtl/tlul_intg_pkg.sv
// TL-UL channel types and command-integrity helpers shared by the host arbiter.
package tlul_intg_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic       a_valid;
    logic [2:0] a_opcode;
    logic [2:0] a_param;
    logic [1:0] a_size;
    logic [7:0] a_source;
    logic [31:0] a_address;
    logic [3:0] a_mask;
    logic [31:0] a_data;
    tl_a_user_t a_user;
    logic       d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic       d_valid;
    logic [2:0] d_opcode;
    logic [2:0] d_param;
    logic [1:0] d_size;
    logic [7:0] d_source;
    logic       d_sink;
    logic [31:0] d_data;
    tl_d_user_t d_user;
    logic       d_error;
    logic       a_ready;
  } tl_d2h_t;

  // Command fields covered by cmd_intg, zero-padded to 57 bits.
  function automatic logic [56:0] tl_cmd_intg_data(input logic [3:0]  instr_type,
                                                   input logic [31:0] address,
                                                   input logic [2:0]  opcode,
                                                   input logic [3:0]  mask);
    return {14'h0, instr_type, address, opcode, mask};
  endfunction

  // Extended Hamming SECDED 64/57: data bits fill the non-power-of-two positions 1..63 in order,
  // check bit b covers positions with bit b set, check bit 6 is overall parity.
  function automatic logic [6:0] secded_64_57_chk(input logic [56:0] data);
    logic [6:0] chk;
    int         k;
    chk = '0;
    k   = 0;
    for (int p = 1; p < 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int b = 0; b < 6; b++) begin
          if (p[b]) chk[b] = chk[b] ^ data[k];
        end
        k++;
      end
    end
    chk[6] = ^{data, chk[5:0]};
    return chk;
  endfunction

endpackage

// File: rtl/tlul_intg_host_arb.sv
// Round-robin TL-UL host arbiter with grant lock, in-order response routing FIFO and
// regenerated command integrity on the downstream request.
module tlul_intg_host_arb
  import tlul_intg_pkg::*;
#(
  parameter int unsigned NumHosts       = 2,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_h_i [NumHosts],
  output tl_d2h_t tl_h_o [NumHosts],
  output tl_h2d_t tl_d_o,
  input  tl_d2h_t tl_d_i
);

  localparam int unsigned IdxW = $clog2(NumHosts);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d, rr_q, rr_d;
  logic [IdxW-1:0] sel, cand, gnt_idx, head;
  logic            sel_found;
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic            fifo_full, fifo_empty, a_hs, push, pop;

  // First requesting host at or after the round-robin pointer.
  always_comb begin
    sel       = rr_q;
    cand      = rr_q;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < NumHosts; i++) begin
      cand = IdxW'((32'(rr_q) + i) % NumHosts);
      if (!sel_found && tl_h_i[cand].a_valid) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
  end

  assign gnt_idx    = (state_q == StLocked) ? gnt_q : sel;
  assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rd_q];

  // Downstream request: granted host's fields, gated valid, regenerated cmd_intg.
  always_comb begin
    tl_d_o                 = tl_h_i[gnt_idx];
    tl_d_o.a_valid         = tl_h_i[gnt_idx].a_valid & ~fifo_full;
    tl_d_o.a_user.cmd_intg = secded_64_57_chk(tl_cmd_intg_data(tl_h_i[gnt_idx].a_user.instr_type,
                                                               tl_h_i[gnt_idx].a_address,
                                                               tl_h_i[gnt_idx].a_opcode,
                                                               tl_h_i[gnt_idx].a_mask));
    // With nothing outstanding any response is stray and is sunk.
    tl_d_o.d_ready         = fifo_empty ? 1'b1 : tl_h_i[head].d_ready;
  end

  assign a_hs = tl_d_o.a_valid & tl_d_i.a_ready;
  assign push = a_hs;
  assign pop  = tl_d_i.d_valid & tl_d_o.d_ready & ~fifo_empty;

  // Per-host responses: a_ready only to the requesting granted host, d_valid only to FIFO head.
  always_comb begin
    for (int unsigned h = 0; h < NumHosts; h++) begin
      tl_h_o[h]         = tl_d_i;
      tl_h_o[h].a_ready = (gnt_idx == IdxW'(h)) & tl_h_i[h].a_valid & tl_d_i.a_ready & ~fifo_full;
      tl_h_o[h].d_valid = tl_d_i.d_valid & ~fifo_empty & (head == IdxW'(h));
    end
  end

  // Grant FSM and round-robin pointer next state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found && !tl_d_i.a_ready) begin
          state_d = StLocked;
          gnt_d   = sel;
        end
      end
      StLocked: begin
        if (a_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (a_hs) rr_d = (gnt_idx == IdxW'(NumHosts - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Routing FIFO pointer and occupancy next state; pointers wrap as powers of two.
  always_comb begin
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop  ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      rr_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Routing FIFO storage; entries are only read while counted, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_q] <= gnt_idx;
  end

  a_fifo_bounds: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (cnt_q <= CntW'(MaxOutstanding)) && !(push && fifo_full && !pop) && !(pop && fifo_empty));

  a_gnt_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == StLocked && state_d == StLocked) |=> $stable(gnt_q));

endmodule
